// File: rtl/id_ex_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_if
// Brief    : ID/EX pipeline bus: decode-side inputs and EX-side registered copies.
// Revision : 1.0
// ============================================================================
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              inValid;
    logic [7:0]        ctrlIn;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [DATA_W-1:0] rs1Data;
    logic [DATA_W-1:0] rs2Data;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [3:0]        funct;
    logic              exFlush;

    logic [7:0]        ctrlOut;
    logic [4:0]        rs1Out;
    logic [4:0]        rs2Out;
    logic [4:0]        rdOut;
    logic [DATA_W-1:0] rs1DataOut;
    logic [DATA_W-1:0] rs2DataOut;
    logic [DATA_W-1:0] immOut;
    logic [DATA_W-1:0] pcOut;
    logic [3:0]        functOut;
    logic              outValid;
    logic              stall;
    logic [CNT_W-1:0]  bubbleCount;

    modport master (
        output inValid, ctrlIn, rs1, rs2, rd, rs1Data, rs2Data, imm, pc, funct, exFlush,
        input  ctrlOut, rs1Out, rs2Out, rdOut, rs1DataOut, rs2DataOut, immOut, pcOut,
               functOut, outValid, stall, bubbleCount
    );

    modport slave (
        input  inValid, ctrlIn, rs1, rs2, rd, rs1Data, rs2Data, imm, pc, funct, exFlush,
        output ctrlOut, rs1Out, rs2Out, rdOut, rs1DataOut, rs2DataOut, immOut, pcOut,
               functOut, outValid, stall, bubbleCount
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with flush and load-use bubble insertion.
//            Define HAZARD_DETECT_EN to enable load-use stall detection.
// Revision : 1.0
// ============================================================================
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    id_ex_if.slave    bus
);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [7:0]        r_ctrl;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [4:0]        r_rd;
    logic [DATA_W-1:0] r_rs1_data;
    logic [DATA_W-1:0] r_rs2_data;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_pc;
    logic [3:0]        r_funct;
    logic              r_valid;
    logic [CNT_W-1:0]  r_cnt;

    logic w_stall;
    logic w_bubble;

`ifdef HAZARD_DETECT_EN
    logic w_uses_rs2;
    logic w_hazard;

    // rs2 is a real source unless the immediate replaces it (stores still read it)
    assign w_uses_rs2 = !bus.ctrlIn[1] || bus.ctrlIn[2];
    assign w_hazard   = r_valid && r_ctrl[6] && (r_rd != 5'd0) && bus.inValid &&
                        ((r_rd == bus.rs1) || ((r_rd == bus.rs2) && w_uses_rs2));
    assign w_stall    = w_hazard && !bus.exFlush;
`else
    assign w_stall    = 1'b0;
`endif

    assign w_bubble = bus.exFlush || w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl     <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
            r_funct    <= '0;
            r_valid    <= 1'b0;
            r_cnt      <= '0;
        end else if (w_bubble) begin
            // data fields of a bubble are never consumed, so they simply hold
            r_ctrl  <= '0;
            r_valid <= 1'b0;
            if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end else begin
            r_ctrl     <= bus.inValid ? bus.ctrlIn : 8'd0;
            r_valid    <= bus.inValid;
            r_rs1      <= bus.rs1;
            r_rs2      <= bus.rs2;
            r_rd       <= bus.rd;
            r_rs1_data <= bus.rs1Data;
            r_rs2_data <= bus.rs2Data;
            r_imm      <= bus.imm;
            r_pc       <= bus.pc;
            r_funct    <= bus.funct;
        end
    end

    assign bus.ctrlOut     = r_ctrl;
    assign bus.rs1Out      = r_rs1;
    assign bus.rs2Out      = r_rs2;
    assign bus.rdOut       = r_rd;
    assign bus.rs1DataOut  = r_rs1_data;
    assign bus.rs2DataOut  = r_rs2_data;
    assign bus.immOut      = r_imm;
    assign bus.pcOut       = r_pc;
    assign bus.functOut    = r_funct;
    assign bus.outValid    = r_valid;
    assign bus.stall       = w_stall;
    assign bus.bubbleCount = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Scoreboard bench for id_ex_stage (default CNT_W plus a CNT_W=4 copy).
// Revision : 1.0
// ============================================================================
`timescale 1ns/100ps
module tb_id_ex_stage;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_ex_if #(.DATA_W(DW), .CNT_W(16)) ifm ();
    id_ex_if #(.DATA_W(DW), .CNT_W(4))  if4 ();

    id_ex_stage #(.DATA_W(DW), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(ifm.slave));
    id_ex_stage #(.DATA_W(DW), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    assign if4.inValid = ifm.inValid;
    assign if4.ctrlIn  = ifm.ctrlIn;
    assign if4.rs1     = ifm.rs1;
    assign if4.rs2     = ifm.rs2;
    assign if4.rd      = ifm.rd;
    assign if4.rs1Data = ifm.rs1Data;
    assign if4.rs2Data = ifm.rs2Data;
    assign if4.imm     = ifm.imm;
    assign if4.pc      = ifm.pc;
    assign if4.funct   = ifm.funct;
    assign if4.exFlush = ifm.exFlush;

    typedef struct {
        bit          valid;
        bit [7:0]    ctrl;
        bit [4:0]    rs1, rs2, rd;
        bit [DW-1:0] d1, d2, imm, pc;
        bit [3:0]    funct;
    } instr_t;

    typedef struct {
        bit          bubble;
        bit          valid;
        bit [7:0]    ctrl;
        bit [4:0]    rs1, rs2, rd;
        bit [DW-1:0] d1, d2, imm, pc;
        bit [3:0]    funct;
        int          cnt;
        int          cnt4;
    } exp_t;

    exp_t exp_q[$];
    bit   stall_q[$];

    int checks   = 0;
    int failures = 0;

    // architectural view of the EX stage, kept by the bench
    bit       m_valid;
    bit [7:0] m_ctrl;
    bit [4:0] m_rd;
    int       m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("outValid", ifm.outValid, e.valid);
            chk("ctrlOut", ifm.ctrlOut, e.ctrl);
            chk("bubbleCount", ifm.bubbleCount, e.cnt);
            chk("outValid4", if4.outValid, e.valid);
            chk("bubbleCount4", if4.bubbleCount, e.cnt4);
            if (!e.bubble) begin
                chk("rs1Out", ifm.rs1Out, e.rs1);
                chk("rs2Out", ifm.rs2Out, e.rs2);
                chk("rdOut", ifm.rdOut, e.rd);
                chk("rs1DataOut", ifm.rs1DataOut, e.d1);
                chk("rs2DataOut", ifm.rs2DataOut, e.d2);
                chk("immOut", ifm.immOut, e.imm);
                chk("pcOut", ifm.pcOut, e.pc);
                chk("functOut", ifm.functOut, e.funct);
            end
        end
    end

    always begin
        bit s;
        @(negedge clk);
        #2;
        if (stall_q.size() > 0) begin
            s = stall_q.pop_front();
            chk("stall", ifm.stall, s);
        end
    end

    function automatic instr_t mk(input bit v, input bit [7:0] c,
                                  input bit [4:0] a, input bit [4:0] b, input bit [4:0] d);
        instr_t t;
        t.valid = v; t.ctrl = c; t.rs1 = a; t.rs2 = b; t.rd = d;
        t.d1 = $urandom; t.d2 = $urandom; t.imm = $urandom; t.pc = $urandom;
        t.funct = 4'($urandom);
        return t;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        t = mk($urandom_range(0, 7) != 0, 8'($urandom),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        t.ctrl[6] = ($urandom_range(0, 1) == 1);
        return t;
    endfunction

    task automatic set_idle();
        ifm.inValid = 1'b0; ifm.ctrlIn = '0; ifm.rs1 = '0; ifm.rs2 = '0; ifm.rd = '0;
        ifm.rs1Data = '0; ifm.rs2Data = '0; ifm.imm = '0; ifm.pc = '0;
        ifm.funct = '0; ifm.exFlush = 1'b0;
    endtask

    task automatic drive_one(input instr_t ins, input bit flush, output bit stalled);
        exp_t e;
        bit   hz;
        bit   bub;
        @(negedge clk);
        #1;
        ifm.inValid = ins.valid; ifm.ctrlIn = ins.ctrl;
        ifm.rs1 = ins.rs1; ifm.rs2 = ins.rs2; ifm.rd = ins.rd;
        ifm.rs1Data = ins.d1; ifm.rs2Data = ins.d2; ifm.imm = ins.imm; ifm.pc = ins.pc;
        ifm.funct = ins.funct; ifm.exFlush = flush;
        hz = 1'b0;
`ifdef HAZARD_DETECT_EN
        // a load in EX feeds a nonzero register the incoming instruction actually reads
        hz = m_valid && m_ctrl[6] && (m_rd != 0) && ins.valid &&
             ((m_rd == ins.rs1) || ((m_rd == ins.rs2) && (!ins.ctrl[1] || ins.ctrl[2])));
`endif
        stalled = hz && !flush;
        stall_q.push_back(stalled);
        bub = flush || stalled;
        if (bub) begin
            m_cnt++;
            m_valid = 1'b0;
            m_ctrl  = '0;
        end else begin
            m_valid = ins.valid;
            m_ctrl  = ins.valid ? ins.ctrl : 8'd0;
            m_rd    = ins.rd;
        end
        e.bubble = bub; e.valid = m_valid; e.ctrl = m_ctrl;
        e.rs1 = ins.rs1; e.rs2 = ins.rs2; e.rd = ins.rd;
        e.d1 = ins.d1; e.d2 = ins.d2; e.imm = ins.imm; e.pc = ins.pc; e.funct = ins.funct;
        e.cnt  = (m_cnt > 65535) ? 65535 : m_cnt;
        e.cnt4 = (m_cnt > 15) ? 15 : m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic issue(input instr_t ins, input bit flush);
        bit st;
        int tries;
        drive_one(ins, flush, st);
        tries = 0;
        while (st && tries < 4) begin
            drive_one(ins, 1'b0, st);
            tries++;
        end
        if (st) chk("stall_release", 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        #2;
        exp_q.delete();
        stall_q.delete();
        rst = 1'b1;
        set_idle();
        #1;
        chk("rst_ctrlOut", ifm.ctrlOut, 0);
        chk("rst_outValid", ifm.outValid, 0);
        chk("rst_rdOut", ifm.rdOut, 0);
        chk("rst_rs1Out", ifm.rs1Out, 0);
        chk("rst_rs2Out", ifm.rs2Out, 0);
        chk("rst_rs1DataOut", ifm.rs1DataOut, 0);
        chk("rst_rs2DataOut", ifm.rs2DataOut, 0);
        chk("rst_immOut", ifm.immOut, 0);
        chk("rst_pcOut", ifm.pcOut, 0);
        chk("rst_functOut", ifm.functOut, 0);
        chk("rst_bubbleCount", ifm.bubbleCount, 0);
        chk("rst_bubbleCount4", if4.bubbleCount, 0);
        chk("rst_stall", ifm.stall, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        m_valid = 1'b0; m_ctrl = '0; m_rd = '0; m_cnt = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit st;
        set_idle();
        do_reset();

        // load-use on rs1, load to x0, immediate form, store, flush-vs-hazard
        issue(mk(1, 8'h63, 5'd8, 5'd0, 5'd5), 1'b0);
        issue(mk(1, 8'h11, 5'd5, 5'd7, 5'd6), 1'b0);
        issue(mk(1, 8'h63, 5'd8, 5'd0, 5'd0), 1'b0);
        issue(mk(1, 8'h11, 5'd0, 5'd7, 5'd6), 1'b0);
        issue(mk(1, 8'h63, 5'd8, 5'd0, 5'd5), 1'b0);
        issue(mk(1, 8'h13, 5'd7, 5'd5, 5'd6), 1'b0);
        issue(mk(1, 8'h63, 5'd8, 5'd0, 5'd5), 1'b0);
        issue(mk(1, 8'h06, 5'd8, 5'd5, 5'd0), 1'b0);
        issue(mk(1, 8'h63, 5'd8, 5'd0, 5'd5), 1'b0);
        issue(mk(1, 8'h11, 5'd5, 5'd7, 5'd6), 1'b1);
        issue(mk(1, 8'h11, 5'd1, 5'd2, 5'd3), 1'b0);

        // reset while a load-use stall is being requested
        issue(mk(1, 8'h63, 5'd8, 5'd0, 5'd5), 1'b0);
        drive_one(mk(1, 8'h11, 5'd5, 5'd7, 5'd6), 1'b0, st);
        do_reset();

        // saturation of the narrow counter
        for (int i = 0; i < 17; i++) issue(rand_instr(), 1'b1);
        issue(mk(1, 8'h11, 5'd1, 5'd2, 5'd3), 1'b0);

        for (int i = 0; i < 1500; i++) begin
            issue(rand_instr(), $urandom_range(0, 7) == 0);
            if (i % 500 == 499) do_reset();
        end

        for (int i = 0; i < 10 && (exp_q.size() > 0 || stall_q.size() > 0); i++) @(negedge clk);
        #3;
        if (exp_q.size() > 0 || stall_q.size() > 0) chk("drain", 1'b1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
